// File: rtl/ssd_pkg.sv
// Shared widths, FSM state type and active-low segment codes for the
// seven-segment debug display driver.
package ssd_pkg;
    localparam int VALUE_W    = 13;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
endpackage

// File: rtl/ssd_if.sv
// SSD debug bus: the CPU drives the value, the display driver owns the pins.
interface ssd_if;
    import ssd_pkg::*;

    logic [VALUE_W-1:0]    value;
    logic                  busy;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            seg;
    logic                  dp;

    modport master (output value, input busy, input anode, input seg, input dp);
    modport slave  (input value, output busy, output anode, output seg, output dp);
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module bcd_to_7seg
    import ssd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_driver.sv
// Shows the 13-bit CPU debug value in decimal on a 4-digit common-anode
// display: serial double-dabble conversion plus a prescaled digit scan.
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic  clk,
    input logic  rst,
    ssd_if.slave ssd
);

    localparam int              SHIFT_W  = BCD_W + VALUE_W;
    localparam logic [3:0]      CNT_LAST = 4'(VALUE_W - 1);
    localparam int              PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    state_t               state_q;
    logic [VALUE_W-1:0]   last_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_d;
    logic [3:0]           cnt_q;
    logic [BCD_W-1:0]     digits_q;
    logic                 busy_q;

    logic [PRE_W-1:0]     prescale_q;
    logic [1:0]           sel_q;
    logic [3:0]           anode_q;
    logic [6:0]           seg_q;
    logic [6:0]           seg_d;
    logic [3:0]           cur_digit;
    logic [3:0]           blank_vec;
    logic                 z3, z2, z1;

    // One double-dabble step: correct every BCD nibble >= 5, then shift
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shift_q[VALUE_W + 4*i +: 4] >= 4'd5) begin
                shift_d[VALUE_W + 4*i +: 4] = shift_q[VALUE_W + 4*i +: 4] + 4'd3;
            end
        end
        shift_d = {shift_d[SHIFT_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ssd.value != last_q) begin
                        last_q  <= ssd.value;
                        shift_q <= {{BCD_W{1'b0}}, ssd.value};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    digits_q <= shift_q[SHIFT_W-1 -: BCD_W];
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign z3 = (digits_q[15:12] == 4'd0);
    assign z2 = (digits_q[11:8]  == 4'd0);
    assign z1 = (digits_q[7:4]   == 4'd0);
    // Units is never blanked so a zero value still shows "0"
    assign blank_vec = BLANK_LZ ? {z3, z3 & z2, z3 & z2 & z1, 1'b0} : 4'b0000;
    assign cur_digit = digits_q[{sel_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .digit_i (cur_digit),
        .blank_i (blank_vec[sel_q]),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            sel_q      <= 2'd0;
            anode_q    <= 4'b1110;
            seg_q      <= SEG_0;
        end else begin
            if (prescale_q == PRE_LAST) begin
                prescale_q <= '0;
                sel_q      <= sel_q + 2'd1;
            end else begin
                prescale_q <= prescale_q + 1'b1;
            end
            anode_q <= ~(4'b0001 << sel_q);
            seg_q   <= seg_d;
        end
    end

    assign ssd.busy  = busy_q;
    assign ssd.anode = anode_q;
    assign ssd.seg   = seg_q;
    assign ssd.dp    = 1'b1;

endmodule

// File: tb/tb_ssd_driver.sv
// Directed bench for ssd_driver: conversion latency, scan order, blanking,
// mid-conversion value changes and reset during conversion.
module tb_ssd_driver;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [6:0] shown[4];

    ssd_if ssd_lz ();
    ssd_if ssd_nlz ();

    ssd_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .ssd (ssd_lz)
    );

    ssd_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nlz (
        .clk (clk),
        .rst (rst),
        .ssd (ssd_nlz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the segment pattern seen under each anode over a full rotation
    task automatic scan_display(input bit nlz, output int bad_anode);
        logic [3:0] a;
        logic [6:0] s;
        bad_anode = 0;
        for (int i = 0; i < 4; i++) shown[i] = 7'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = nlz ? ssd_nlz.anode : ssd_lz.anode;
            s = nlz ? ssd_nlz.seg : ssd_lz.seg;
            case (a)
                4'b1110: shown[0] = s;
                4'b1101: shown[1] = s;
                4'b1011: shown[2] = s;
                4'b0111: shown[3] = s;
                default: bad_anode++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ssd_lz.value = '0;
        ssd_nlz.value = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ssd_lz.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b expected 0", ssd_lz.busy);
        end
        tests_run++;
        if (ssd_lz.anode !== 4'b1110) begin
            tests_failed++; $display("FAIL reset_anode: got %b expected 1110", ssd_lz.anode);
        end
        tests_run++;
        if (ssd_lz.seg !== 7'b1000000) begin
            tests_failed++; $display("FAIL reset_seg: got %b expected 1000000", ssd_lz.seg);
        end
        tests_run++;
        if (ssd_lz.dp !== 1'b1) begin
            tests_failed++; $display("FAIL reset_dp: got %b expected 1", ssd_lz.dp);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_zero_scan();
        logic [3:0] prev;
        logic [6:0] exp_seg;
        int run, busy_seen, transitions, seg_err;
        prev = ssd_lz.anode;
        run = 0; busy_seen = 0; transitions = 0; seg_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ssd_lz.busy !== 1'b0) busy_seen++;
            exp_seg = (ssd_lz.anode == 4'b1110) ? 7'b1000000 : 7'b1111111;
            if (ssd_lz.seg !== exp_seg) seg_err++;
            if (ssd_lz.anode !== prev) begin
                tests_run++;
                if (ssd_lz.anode !== {prev[2:0], prev[3]}) begin
                    tests_failed++;
                    $display("FAIL scan_order: got %b expected %b", ssd_lz.anode, {prev[2:0], prev[3]});
                end
                if (transitions > 0) begin
                    tests_run++;
                    if (run != 4) begin
                        tests_failed++; $display("FAIL scan_dwell: got %0d expected 4", run);
                    end
                end
                transitions++;
                run = 1;
                prev = ssd_lz.anode;
            end else begin
                run++;
            end
        end
        tests_run++;
        if (busy_seen != 0) begin
            tests_failed++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen);
        end
        tests_run++;
        if (seg_err != 0) begin
            tests_failed++; $display("FAIL zero_seg: got %0d bad cycles expected 0", seg_err);
        end
        tests_run++;
        if (transitions < 8) begin
            tests_failed++; $display("FAIL scan_rotate: got %0d transitions expected >= 8", transitions);
        end
    endtask

    task automatic test_1234();
        int cnt, first, last, bad;
        logic [6:0] exp[4];
        exp[3] = 7'b1111001; exp[2] = 7'b0100100; exp[1] = 7'b0110000; exp[0] = 7'b0011001;
        @(posedge clk); #1 ssd_lz.value = 13'd1234;
        cnt = 0; first = -1; last = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ssd_lz.busy === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        tests_run++;
        if (cnt != 14 || first != 1 || last != 14) begin
            tests_failed++;
            $display("FAIL busy_1234: got %0d cycles k=%0d..%0d expected 14 cycles k=1..14", cnt, first, last);
        end
        scan_display(1'b0, bad);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (shown[i] !== exp[i]) begin
                tests_failed++; $display("FAIL digit_1234[%0d]: got %b expected %b", i, shown[i], exp[i]);
            end
        end
    endtask

    task automatic test_patterns();
        logic [12:0] vals[3];
        logic [27:0] exps[3];
        logic [6:0]  e;
        int bad;
        vals[0] = 13'd8191; exps[0] = {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001};
        vals[1] = 13'd7;    exps[1] = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
        vals[2] = 13'd1005; exps[2] = {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010};
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1 ssd_lz.value = vals[t];
            repeat (20) @(posedge clk);
            scan_display(1'b0, bad);
            tests_run++;
            if (bad != 0) begin
                tests_failed++; $display("FAIL onehot_%0d: got %0d bad anode cycles expected 0", vals[t], bad);
            end
            for (int i = 0; i < 4; i++) begin
                e = exps[t][7*i +: 7];
                tests_run++;
                if (shown[i] !== e) begin
                    tests_failed++;
                    $display("FAIL digit_%0d[%0d]: got %b expected %b", vals[t], i, shown[i], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_err, hits100, err100, hits200, err200;
        logic exp_busy;
        busy_err = 0; hits100 = 0; err100 = 0; hits200 = 0; err200 = 0;
        @(posedge clk); #1 ssd_lz.value = 13'd100;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 5) ssd_lz.value = 13'd200;
            exp_busy = (k >= 1 && k <= 14) || (k >= 16 && k <= 29);
            if (ssd_lz.busy !== exp_busy) busy_err++;
            if (ssd_lz.anode == 4'b1011) begin
                if (k >= 16 && k <= 30) begin
                    hits100++;
                    if (ssd_lz.seg !== 7'b1111001) err100++;
                end else if (k >= 31) begin
                    hits200++;
                    if (ssd_lz.seg !== 7'b0100100) err200++;
                end
            end
        end
        tests_run++;
        if (busy_err != 0) begin
            tests_failed++; $display("FAIL b2b_busy: got %0d wrong cycles expected 0", busy_err);
        end
        tests_run++;
        if (hits100 == 0 || err100 != 0) begin
            tests_failed++; $display("FAIL b2b_show100: got %0d bad of %0d expected 0 bad", err100, hits100);
        end
        tests_run++;
        if (hits200 == 0 || err200 != 0) begin
            tests_failed++; $display("FAIL b2b_show200: got %0d bad of %0d expected 0 bad", err200, hits200);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, first, bad;
        logic [6:0] exp[4];
        exp[3] = 7'b0011001; exp[2] = 7'b0110000; exp[1] = 7'b0100100; exp[0] = 7'b1111001;
        @(posedge clk); #1 ssd_lz.value = 13'd4321;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (ssd_lz.busy !== 1'b0 || ssd_lz.anode !== 4'b1110 || ssd_lz.seg !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got busy=%b anode=%b seg=%b expected 0 1110 1000000",
                     ssd_lz.busy, ssd_lz.anode, ssd_lz.seg);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ssd_lz.busy === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        tests_run++;
        if (cnt != 14 || first != 1) begin
            tests_failed++;
            $display("FAIL midrst_busy: got %0d cycles first k=%0d expected 14 cycles first k=1", cnt, first);
        end
        scan_display(1'b0, bad);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (shown[i] !== exp[i]) begin
                tests_failed++; $display("FAIL digit_4321[%0d]: got %b expected %b", i, shown[i], exp[i]);
            end
        end
    endtask

    task automatic test_no_blank();
        int bad;
        logic [6:0] exp_n[4];
        logic [6:0] exp_b[4];
        exp_n[3] = 7'b1000000; exp_n[2] = 7'b1000000; exp_n[1] = 7'b0011001; exp_n[0] = 7'b0100100;
        exp_b[3] = 7'b1111111; exp_b[2] = 7'b1111111; exp_b[1] = 7'b0011001; exp_b[0] = 7'b0100100;
        @(posedge clk); #1;
        ssd_nlz.value = 13'd42;
        ssd_lz.value  = 13'd42;
        repeat (20) @(posedge clk);
        scan_display(1'b1, bad);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (shown[i] !== exp_n[i]) begin
                tests_failed++; $display("FAIL nolz_42[%0d]: got %b expected %b", i, shown[i], exp_n[i]);
            end
        end
        scan_display(1'b0, bad);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (shown[i] !== exp_b[i]) begin
                tests_failed++; $display("FAIL lz_42[%0d]: got %b expected %b", i, shown[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_zero_scan();
        test_1234();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_no_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ssd_driver.md
Name: ssd_driver

Overview:
- Receives the 13-bit debug value the CPU top drives on its SSD bus and displays it in decimal on a 4-digit, common-anode seven-segment display.
- Converts binary to 4 BCD digits with an iterative double-dabble FSM, one bit per cycle.
- Time-multiplexes the digits with a prescaled scan counter.
- Sits on the board-top side of the CPU debug output, between the CPU's SSD bus and the display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Minimum 2. Simulation uses 4.
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  13  binary value to display, range 0..8191.
- busy  out  1  high while a conversion is in progress.
- anode  out  4  active-low digit enables. Bit 0 = units, bit 3 = thousands.
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, constant 1 (off).

Behaviour:
- Reset values:
  - state=IDLE, last_q=0, digits_q={0,0,0,0}, prescale=0, sel=0, busy=0.
  - anode=4'b1110, seg=7'b1000000 (units "0"), dp=1.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: if value != last_q, then at the clock edge last_q<=value, shift_q<={16'b0,value}, cnt<=0, state<=CONV. Otherwise stay in IDLE.
  - CONV: each cycle, for each of the 4 BCD nibbles that is >=5, add 3; then shift the 29-bit {bcd,bin} register left by 1 and increment cnt. When cnt reaches 12 (the 13th shift), state<=COMMIT.
  - COMMIT: digits_q<=bcd nibbles; state<=IDLE.
- busy is high in CONV and COMMIT, low in IDLE.
- Latency: with a value change presented in IDLE at edge 0, digits_q updates at edge 15, and the new digit appears on anode/seg one cycle after that.
- value changes while busy are ignored for that conversion. Back in IDLE, value is compared against last_q again, so the display always converges to the final stable value.
- Max input 8191 produces digits 8,1,9,1. No overflow is possible: 4 nibbles hold 9999.
- Scan:
  - prescale counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, sel<=sel+1 mod 4 (3 wraps to 0).
  - anode and seg are registered from sel and digits_q. Exactly one anode bit is low at all times after reset.
- Leading-zero blanking (BLANK_LZ=1):
  - thousands blank if d3==0.
  - hundreds blank if d3==0 and d2==0.
  - tens blank if d3, d2, d1 are all 0.
  - units never blank.
  - A blanked digit keeps its anode asserted with seg=7'b1111111.
- Segment codes (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10-15 cannot occur; decode them to 7'b1111111.
- Reset asserted mid-conversion:
  - Immediately returns all state to reset values; the partial result is discarded.
  - After release, a nonzero value starts a fresh conversion on the first clock.

Decomposition:
- Package ssd_pkg holds:
  - VALUE_W=13 and NUM_DIGITS=4.
  - The state enum {IDLE,CONV,COMMIT}.
  - SEG_BLANK=7'b1111111 and the ten digit segment constants.
- One sub-module, bcd_to_7seg: combinational, 4-bit digit plus blank input in, 7-bit seg out.
- The top holds the FSM, the double-dabble datapath, the scan counters and the output registers.

Test Plan:
- Reset, then value=0 held -> busy never rises. anode cycles 1110,1101,1011,0111, each held REFRESH_DIV=4 clks. seg=1000000 on units, 1111111 on the other digits.
- value=1234 -> busy high for 14 cycles, digits_q={1,2,3,4} at edge 15. seg per anode: 0111->1111001, 1011->0100100, 1101->0110000, 1110->0011001.
- value=8191 -> digits {8,1,9,1}. value=7 -> only units lit with 1111000, upper three 1111111. value=1005 with BLANK_LZ=1 -> hundreds and tens show 1000000 (not blanked).
- value=100, then value=200 at cycle 5 while busy -> display shows 100 after edge 15, busy re-asserts at cycle 16, display shows 200 after edge 31.
- value=4321, assert rst at cycle 7 for 2 cycles -> outputs return to reset values immediately. After release, a conversion restarts and 4321 appears 15 edges later.
- BLANK_LZ=0, value=42 -> thousands and hundreds show 1000000.
